// File: rtl/branch_unit.sv
// branch_unit: resolves 6502-style conditional relative branches and JMP.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            one-cycle request strobe, accepted only in IDLE
//   op, jmp_ind      opcode and JMP addressing mode (1 = indirect)
//   operand          relative offset in [7:0], or JMP target / pointer
//   pc, flags        address after the branch; status register N V - - - - Z C
//   mem_addr, mem_rd byte read request, held until mem_valid
//   mem_data         read data, qualified by mem_valid
//   busy, done       non-IDLE indicator; one-cycle completion pulse
//   taken, new_pc    redirect flag and resolved next PC
//   penalty          extra cycles for a taken branch (1, or 2 on page cross)
//   illegal          op was not a supported opcode
module branch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic        jmp_ind,
    input  logic [15:0] operand,
    input  logic [15:0] pc,
    input  logic [7:0]  flags,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_valid,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic [15:0] new_pc,
    output logic [1:0]  penalty,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE, EVAL, PEN1, PEN2, RD_LO, RD_HI, FIN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic        jmp_ind_q, jmp_ind_d;
    logic [15:0] operand_q, operand_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  flags_q, flags_d;
    logic [7:0]  lo_q, lo_d;
    logic        taken_q, taken_d;
    logic [15:0] new_pc_q, new_pc_d;
    logic [1:0]  penalty_q, penalty_d;
    logic        illegal_q, illegal_d;

    logic [15:0] target;
    logic        page_cross;
    logic        is_branch;
    logic        is_jmp;
    logic        cond;

    always_comb begin
        target     = pc_q + {{8{operand_q[7]}}, operand_q[7:0]};
        page_cross = (target[15:8] != pc_q[15:8]);

        is_branch = 1'b1;
        is_jmp    = 1'b0;
        cond      = 1'b0;
        case (op_q)
            8'h04:   cond = ~flags_q[0];
            8'h05:   cond =  flags_q[0];
            8'h06:   cond =  flags_q[1];
            8'h07:   cond =  flags_q[7];
            8'h08:   cond = ~flags_q[1];
            8'h09:   cond = ~flags_q[7];
            8'h0A:   cond = ~flags_q[6];
            8'h0B:   cond =  flags_q[6];
            8'h1C: begin
                is_branch = 1'b0;
                is_jmp    = 1'b1;
            end
            default: is_branch = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        jmp_ind_d = jmp_ind_q;
        operand_d = operand_q;
        pc_d      = pc_q;
        flags_d   = flags_q;
        lo_d      = lo_q;
        taken_d   = taken_q;
        new_pc_d  = new_pc_q;
        penalty_d = penalty_q;
        illegal_d = illegal_q;
        mem_addr  = '0;
        mem_rd    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d      = op;
                    jmp_ind_d = jmp_ind;
                    operand_d = operand;
                    pc_d      = pc;
                    flags_d   = flags;
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                // Result registers are loaded on every transition into FIN,
                // so each path writes all four fields.
                if (is_jmp && jmp_ind_q) begin
                    state_d = RD_LO;
                end else if (is_jmp) begin
                    taken_d   = 1'b1;
                    new_pc_d  = operand_q;
                    penalty_d = 2'd0;
                    illegal_d = 1'b0;
                    state_d   = FIN;
                end else if (is_branch && cond) begin
                    state_d = PEN1;
                end else begin
                    taken_d   = 1'b0;
                    new_pc_d  = pc_q;
                    penalty_d = 2'd0;
                    illegal_d = ~is_branch;
                    state_d   = FIN;
                end
            end
            PEN1: begin
                if (page_cross) begin
                    state_d = PEN2;
                end else begin
                    taken_d   = 1'b1;
                    new_pc_d  = target;
                    penalty_d = 2'd1;
                    illegal_d = 1'b0;
                    state_d   = FIN;
                end
            end
            PEN2: begin
                taken_d   = 1'b1;
                new_pc_d  = target;
                penalty_d = 2'd2;
                illegal_d = 1'b0;
                state_d   = FIN;
            end
            RD_LO: begin
                mem_addr = operand_q;
                mem_rd   = 1'b1;
                if (mem_valid) begin
                    lo_d    = mem_data;
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                // Pointer high byte is fetched from the same page (6502 wrap).
                mem_addr = {operand_q[15:8], operand_q[7:0] + 8'd1};
                mem_rd   = 1'b1;
                if (mem_valid) begin
                    taken_d   = 1'b1;
                    new_pc_d  = {mem_data, lo_q};
                    penalty_d = 2'd0;
                    illegal_d = 1'b0;
                    state_d   = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            jmp_ind_q <= 1'b0;
            operand_q <= '0;
            pc_q      <= '0;
            flags_q   <= '0;
            lo_q      <= '0;
            taken_q   <= 1'b0;
            new_pc_q  <= '0;
            penalty_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            jmp_ind_q <= jmp_ind_d;
            operand_q <= operand_d;
            pc_q      <= pc_d;
            flags_q   <= flags_d;
            lo_q      <= lo_d;
            taken_q   <= taken_d;
            new_pc_q  <= new_pc_d;
            penalty_q <= penalty_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FIN);
    assign taken   = taken_q;
    assign new_pc  = new_pc_q;
    assign penalty = penalty_q;
    assign illegal = illegal_q;

endmodule
